// File: rtl/dram_write_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : dram_write_feeder
//  Purpose  : Buffers the user write stream in a FWFT FIFO and splits a write
//             job into single-outstanding burst requests. A request is issued
//             only once all of its words are already in the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module dram_write_feeder #(
    parameter int MAXBURST_LOG   = 4,
    parameter int WRITENUM_SIZE  = 31,
    parameter int DRAM_ADDRSPACE = 32,
    parameter int DRAM_DATAWIDTH = 512,
    parameter int FIFO_DEPTH_LOG = 5
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        JOB_REQ,
    input  logic [DRAM_ADDRSPACE-1:0]   JOB_INITADDR,
    input  logic [WRITENUM_SIZE:0]      JOB_NUM,
    output logic                        JOB_RDY,
    output logic                        JOB_DONE,
    input  logic [DRAM_DATAWIDTH-1:0]   IN_DATA,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    output logic                        WRITE_REQ,
    output logic [DRAM_ADDRSPACE-1:0]   WRITE_INITADDR,
    output logic [WRITENUM_SIZE:0]      WRITE_NUM,
    output logic [DRAM_DATAWIDTH-1:0]   WRITE_DATA,
    input  logic                        WRITE_DATA_ACCEPTABLE,
    input  logic                        WRITE_RDY,
    input  logic                        WRITE_REQ_DONE,
    output logic [FIFO_DEPTH_LOG:0]     FIFO_COUNT,
    output logic                        UNDERFLOW_ERR
);

    localparam int NW        = WRITENUM_SIZE + 1;
    localparam int CW        = FIFO_DEPTH_LOG + 1;
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG;
    localparam int BYTES_LOG = $clog2(DRAM_DATAWIDTH / 8);
    localparam logic [NW-1:0] c_MAX_BURST = NW'(1) << MAXBURST_LOG;
    localparam logic [CW-1:0] c_DEPTH     = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [DRAM_DATAWIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] r_wptr;
    logic [FIFO_DEPTH_LOG-1:0] r_rptr;
    logic [CW-1:0]             r_count;
    logic                      r_underflow;
    logic                      w_in_ready;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;

    assign w_in_ready = (r_count < c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push     = IN_VALID && w_in_ready;
    assign w_pop      = WRITE_DATA_ACCEPTABLE && !w_empty;

    // Storage array carries no reset; stale contents are unreachable after the
    // pointers clear.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= IN_DATA;
        end
    end

    // Pointer/occupancy bookkeeping and the sticky underflow flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_DEPTH_LOG'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_DEPTH_LOG'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (WRITE_DATA_ACCEPTABLE && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign IN_READY      = w_in_ready;
    assign WRITE_DATA    = r_mem[r_rptr];
    assign FIFO_COUNT    = r_count;
    assign UNDERFLOW_ERR = r_underflow;

    // ------------------------------------------------------------------------
    // Job splitter
    // ------------------------------------------------------------------------
    state_t                    r_state,     w_state_nx;
    logic [DRAM_ADDRSPACE-1:0] r_addr,      w_addr_nx;
    logic [NW-1:0]             r_remaining, w_rem_nx;
    logic [NW-1:0]             r_chunk,     w_chunk_nx;
    logic                      r_write_req, w_write_req_nx;
    logic [DRAM_ADDRSPACE-1:0] r_waddr,     w_waddr_nx;
    logic [NW-1:0]             r_wnum,      w_wnum_nx;
    logic                      r_job_done,  w_job_done_nx;

    logic [NW-1:0]             w_chunk;
    logic [NW-1:0]             w_rem_left;
    logic [DRAM_ADDRSPACE-1:0] w_stride;
    logic                      w_enough;

    assign w_chunk    = (r_remaining > c_MAX_BURST) ? c_MAX_BURST : r_remaining;
    assign w_rem_left = r_remaining - r_chunk;
    assign w_stride   = DRAM_ADDRSPACE'(r_chunk) << BYTES_LOG;
    assign w_enough   = (NW'(r_count) >= w_chunk);

    // State and request registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_chunk     <= '0;
            r_write_req <= 1'b0;
            r_waddr     <= '0;
            r_wnum      <= '0;
            r_job_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_remaining <= w_rem_nx;
            r_chunk     <= w_chunk_nx;
            r_write_req <= w_write_req_nx;
            r_waddr     <= w_waddr_nx;
            r_wnum      <= w_wnum_nx;
            r_job_done  <= w_job_done_nx;
        end
    end

    // Next-state logic; request and done pulses appear one cycle after the
    // deciding condition.
    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_rem_nx       = r_remaining;
        w_chunk_nx     = r_chunk;
        w_write_req_nx = 1'b0;
        w_waddr_nx     = r_waddr;
        w_wnum_nx      = r_wnum;
        w_job_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (JOB_REQ) begin
                    if (JOB_NUM == '0) begin
                        w_job_done_nx = 1'b1;
                    end else begin
                        w_addr_nx  = JOB_INITADDR;
                        w_rem_nx   = JOB_NUM;
                        w_state_nx = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (w_enough && WRITE_RDY) begin
                    w_write_req_nx = 1'b1;
                    w_waddr_nx     = r_addr;
                    w_wnum_nx      = w_chunk;
                    w_chunk_nx     = w_chunk;
                    w_state_nx     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (WRITE_REQ_DONE) begin
                    w_addr_nx = r_addr + w_stride;
                    w_rem_nx  = w_rem_left;
                    if (w_rem_left == '0) begin
                        w_job_done_nx = 1'b1;
                        w_state_nx    = S_IDLE;
                    end else begin
                        w_state_nx = S_WAIT_DATA;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign JOB_RDY        = (r_state == S_IDLE);
    assign JOB_DONE       = r_job_done;
    assign WRITE_REQ      = r_write_req;
    assign WRITE_INITADDR = r_waddr;
    assign WRITE_NUM      = r_wnum;

endmodule
`default_nettype wire

// File: tb/tb_dram_write_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_write_feeder
//  Purpose  : Self-checking bench for dram_write_feeder: FIFO vector table,
//             controller model and directed multi-cycle job sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dram_write_feeder;

    logic         CLK = 1'b0;
    logic         RST;
    logic         JOB_REQ;
    logic [31:0]  JOB_INITADDR;
    logic [31:0]  JOB_NUM;
    logic         JOB_RDY;
    logic         JOB_DONE;
    logic [511:0] IN_DATA;
    logic         IN_VALID;
    logic         IN_READY;
    logic         WRITE_REQ;
    logic [31:0]  WRITE_INITADDR;
    logic [31:0]  WRITE_NUM;
    logic [511:0] WRITE_DATA;
    logic         WRITE_DATA_ACCEPTABLE;
    logic         WRITE_RDY;
    logic         WRITE_REQ_DONE;
    logic [5:0]   FIFO_COUNT;
    logic         UNDERFLOW_ERR;

    logic tb_acc;
    logic ctrl_acc;
    logic ctrl_en;
    assign WRITE_DATA_ACCEPTABLE = tb_acc | ctrl_acc;

    dram_write_feeder dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .JOB_REQ               (JOB_REQ),
        .JOB_INITADDR          (JOB_INITADDR),
        .JOB_NUM               (JOB_NUM),
        .JOB_RDY               (JOB_RDY),
        .JOB_DONE              (JOB_DONE),
        .IN_DATA               (IN_DATA),
        .IN_VALID              (IN_VALID),
        .IN_READY              (IN_READY),
        .WRITE_REQ             (WRITE_REQ),
        .WRITE_INITADDR        (WRITE_INITADDR),
        .WRITE_NUM             (WRITE_NUM),
        .WRITE_DATA            (WRITE_DATA),
        .WRITE_DATA_ACCEPTABLE (WRITE_DATA_ACCEPTABLE),
        .WRITE_RDY             (WRITE_RDY),
        .WRITE_REQ_DONE        (WRITE_REQ_DONE),
        .FIFO_COUNT            (FIFO_COUNT),
        .UNDERFLOW_ERR         (UNDERFLOW_ERR)
    );

    always #5 CLK = ~CLK;

    // Negedge monitor: records events with a slot index, one slot per cycle.
    int          slot = 0;
    int          mon_req = 0;
    logic [31:0] req_addr [16];
    logic [31:0] req_num  [16];
    int          req_slot [16];
    int          jd_cnt = 0;
    int          jd_slot = 0;
    int          rd_slot = 0;
    int          jr_slot = 0;
    int          push_slot = 0;
    int          rdy_low = 0;

    always @(negedge CLK) begin
        slot <= slot + 1;
        if (WRITE_REQ) begin
            if (mon_req < 16) begin
                req_addr[mon_req] <= WRITE_INITADDR;
                req_num[mon_req]  <= WRITE_NUM;
                req_slot[mon_req] <= slot;
            end
            mon_req <= mon_req + 1;
        end
        if (JOB_DONE) begin
            jd_cnt  <= jd_cnt + 1;
            jd_slot <= slot;
        end
        if (WRITE_REQ_DONE) rd_slot <= slot;
        if (JOB_REQ) jr_slot <= slot;
        if (IN_VALID && IN_READY) push_slot <= slot;
        if (!JOB_RDY) rdy_low <= rdy_low + 1;
    end

    // Controller model: on each request pop WRITE_NUM words, checking that the
    // head word follows the running tag sequence, then acknowledge.
    logic [31:0] ctrl_exp;
    int          ctrl_bad;
    initial begin
        ctrl_acc       = 1'b0;
        WRITE_REQ_DONE = 1'b0;
        ctrl_exp       = 32'd0;
        ctrl_bad       = 0;
        forever begin
            @(posedge CLK); #1;
            if (ctrl_en && WRITE_REQ) begin
                for (int k = 0; k < int'(WRITE_NUM); k++) begin
                    if (FIFO_COUNT == 6'd0 || WRITE_DATA !== {16{ctrl_exp}}) ctrl_bad++;
                    ctrl_exp = ctrl_exp + 32'd1;
                    ctrl_acc = 1'b1;
                    @(posedge CLK); #1;
                end
                ctrl_acc       = 1'b0;
                WRITE_REQ_DONE = 1'b1;
                @(posedge CLK); #1;
                WRITE_REQ_DONE = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic start_job(input logic [31:0] addr, input logic [31:0] num);
        JOB_INITADDR = addr;
        JOB_NUM      = num;
        JOB_REQ      = 1'b1;
        tick();
        JOB_REQ      = 1'b0;
    endtask

    // Push n words with tags first..first+n-1, honouring IN_READY.
    task automatic push_words(input int first, input int n, input int budget);
        int  i = 0;
        int  c = 0;
        logic acc;
        while (i < n && c < budget) begin
            IN_VALID = 1'b1;
            IN_DATA  = {16{32'(first + i)}};
            acc      = IN_READY;
            tick();
            c++;
            if (acc) i++;
        end
        IN_VALID = 1'b0;
        chk("push_complete", 512'(i), 512'(n));
    endtask

    task automatic wait_job_done(input int j0, input int budget);
        for (int c = 0; c < budget && jd_cnt == j0; c++) tick();
        chk("job_done_seen", 512'(jd_cnt != j0), 512'(1));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        a;
        int          cnt;
        logic        hchk;
        logic [31:0] head;
    } vec_t;

    vec_t vt [8];
    int   r0, j0, rl0;

    initial begin
        RST = 1'b1; JOB_REQ = 1'b0; JOB_INITADDR = '0; JOB_NUM = '0;
        IN_DATA = '0; IN_VALID = 1'b0; tb_acc = 1'b0; ctrl_en = 1'b0;
        WRITE_RDY = 1'b1;

        // ---- reset state ----
        #12;
        chk("rst_job_rdy",   512'(JOB_RDY),        512'(1));
        chk("rst_in_ready",  512'(IN_READY),       512'(1));
        chk("rst_job_done",  512'(JOB_DONE),       512'(0));
        chk("rst_write_req", 512'(WRITE_REQ),      512'(0));
        chk("rst_waddr",     512'(WRITE_INITADDR), 512'(0));
        chk("rst_wnum",      512'(WRITE_NUM),      512'(0));
        chk("rst_count",     512'(FIFO_COUNT),     512'(0));
        chk("rst_underflow", 512'(UNDERFLOW_ERR),  512'(0));
        @(negedge CLK); RST = 1'b0;
        tick();

        // ---- FIFO vector table: push/pop combinations, no job ----
        vt[0] = '{1'b1, 32'hA0, 1'b0, 1, 1'b1, 32'hA0};
        vt[1] = '{1'b1, 32'hA1, 1'b0, 2, 1'b1, 32'hA0};
        vt[2] = '{1'b1, 32'hA2, 1'b1, 2, 1'b1, 32'hA1};
        vt[3] = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 32'hA2};
        vt[4] = '{1'b0, 32'h00, 1'b0, 1, 1'b1, 32'hA2};
        vt[5] = '{1'b1, 32'hA3, 1'b1, 1, 1'b1, 32'hA3};
        vt[6] = '{1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h00};
        vt[7] = '{1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h00};
        for (int i = 0; i < 8; i++) begin
            IN_VALID = vt[i].v;
            IN_DATA  = {16{vt[i].d}};
            tb_acc   = vt[i].a;
            tick();
            IN_VALID = 1'b0;
            tb_acc   = 1'b0;
            chk($sformatf("vec%0d_count", i), 512'(FIFO_COUNT), 512'(vt[i].cnt));
            chk($sformatf("vec%0d_in_ready", i), 512'(IN_READY), 512'(1));
            chk($sformatf("vec%0d_underflow", i), 512'(UNDERFLOW_ERR), 512'(0));
            if (vt[i].hchk) chk($sformatf("vec%0d_head", i), WRITE_DATA, {16{vt[i].head}});
        end

        // ---- 40-word job split into 16/16/8 bursts ----
        ctrl_en = 1'b1;
        r0 = mon_req; j0 = jd_cnt;
        start_job(32'h1000, 32'd40);
        push_words(0, 40, 400);
        wait_job_done(j0, 400);
        repeat (4) tick();
        chk("j40_req_count", 512'(mon_req - r0), 512'(3));
        chk("j40_req0_addr", 512'(req_addr[r0]),   512'(32'h1000));
        chk("j40_req0_num",  512'(req_num[r0]),    512'(16));
        chk("j40_req1_addr", 512'(req_addr[r0+1]), 512'(32'h1400));
        chk("j40_req1_num",  512'(req_num[r0+1]),  512'(16));
        chk("j40_req2_addr", 512'(req_addr[r0+2]), 512'(32'h1800));
        chk("j40_req2_num",  512'(req_num[r0+2]),  512'(8));
        chk("j40_data_order", 512'(ctrl_bad), 512'(0));
        chk("j40_words_popped", 512'(ctrl_exp), 512'(40));
        chk("j40_done_once", 512'(jd_cnt - j0), 512'(1));
        chk("j40_done_timing", 512'(jd_slot), 512'(rd_slot + 1));
        chk("j40_final_count", 512'(FIFO_COUNT), 512'(0));
        chk("j40_job_rdy", 512'(JOB_RDY), 512'(1));

        // ---- zero-length job ----
        r0 = mon_req; j0 = jd_cnt; rl0 = rdy_low;
        start_job(32'h5000, 32'd0);
        repeat (5) tick();
        chk("j0_done_once",   512'(jd_cnt - j0), 512'(1));
        chk("j0_done_timing", 512'(jd_slot), 512'(jr_slot + 1));
        chk("j0_no_req",      512'(mon_req - r0), 512'(0));
        chk("j0_rdy_high",    512'(rdy_low - rl0), 512'(0));

        // ---- request waits for the 16th word ----
        r0 = mon_req; j0 = jd_cnt;
        start_job(32'h2000, 32'd16);
        push_words(40, 15, 100);
        repeat (20) tick();
        chk("j16_stall_no_req", 512'(mon_req - r0), 512'(0));
        chk("j16_stall_count",  512'(FIFO_COUNT), 512'(15));
        push_words(55, 1, 10);
        for (int c = 0; c < 20 && mon_req == r0; c++) tick();
        tick();
        chk("j16_req_seen",    512'(mon_req - r0), 512'(1));
        chk("j16_req_latency", 512'(req_slot[r0]), 512'(push_slot + 2));
        chk("j16_req_num",     512'(req_num[r0]),  512'(16));
        chk("j16_req_addr",    512'(req_addr[r0]), 512'(32'h2000));
        wait_job_done(j0, 100);
        chk("j16_data_order", 512'(ctrl_bad), 512'(0));
        chk("j16_words_popped", 512'(ctrl_exp), 512'(56));
        ctrl_en = 1'b0;

        // ---- fill to full without a job ----
        begin
            int acc_n = 0;
            for (int c = 0; c < 40; c++) begin
                IN_VALID = 1'b1;
                IN_DATA  = {16{32'(1000 + acc_n)}};
                if (IN_READY) acc_n++;
                tick();
            end
            chk("full_accepted", 512'(acc_n), 512'(32));
        end
        chk("full_count",    512'(FIFO_COUNT), 512'(32));
        chk("full_in_ready", 512'(IN_READY),   512'(0));
        chk("full_head",     WRITE_DATA, {16{32'd1000}});
        repeat (3) tick();
        chk("full_hold_count", 512'(FIFO_COUNT), 512'(32));
        chk("full_hold_head",  WRITE_DATA, {16{32'd1000}});
        IN_VALID = 1'b0;
        RST = 1'b1; #3;
        chk("rst_clears_count", 512'(FIFO_COUNT), 512'(0));
        @(negedge CLK); RST = 1'b0;
        tick();

        // ---- underflow is sticky ----
        tb_acc = 1'b1;
        tick();
        tb_acc = 1'b0;
        chk("uf_flag",  512'(UNDERFLOW_ERR), 512'(1));
        chk("uf_count", 512'(FIFO_COUNT),    512'(0));
        repeat (2) tick();
        chk("uf_sticky", 512'(UNDERFLOW_ERR), 512'(1));

        // ---- reset while waiting for the controller ----
        r0 = mon_req;
        start_job(32'h3000, 32'd10);
        push_words(32'hAA00, 10, 50);
        for (int c = 0; c < 20 && !WRITE_REQ; c++) tick();
        chk("wd_req_high",   512'(WRITE_REQ),     512'(1));
        chk("wd_count",      512'(FIFO_COUNT),    512'(10));
        chk("wd_uf_sticky",  512'(UNDERFLOW_ERR), 512'(1));
        chk("wd_job_busy",   512'(JOB_RDY),       512'(0));
        #2 RST = 1'b1;
        #1;
        chk("async_rst_req",   512'(WRITE_REQ),     512'(0));
        chk("async_rst_count", 512'(FIFO_COUNT),    512'(0));
        chk("async_rst_rdy",   512'(JOB_RDY),       512'(1));
        chk("async_rst_uf",    512'(UNDERFLOW_ERR), 512'(0));
        @(negedge CLK); RST = 1'b0;
        tick();

        // ---- job after reset completes normally ----
        ctrl_en = 1'b1;
        r0 = mon_req; j0 = jd_cnt;
        start_job(32'h4000, 32'd4);
        push_words(56, 4, 50);
        wait_job_done(j0, 100);
        repeat (2) tick();
        chk("j4_req_count", 512'(mon_req - r0), 512'(1));
        chk("j4_req_addr",  512'(req_addr[r0]), 512'(32'h4000));
        chk("j4_req_num",   512'(req_num[r0]),  512'(4));
        chk("j4_data_order", 512'(ctrl_bad), 512'(0));
        chk("j4_words_popped", 512'(ctrl_exp), 512'(60));
        chk("j4_final_count", 512'(FIFO_COUNT), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_write_feeder.md
Name: dram_write_feeder

Overview:
Upstream stage of the DRAM write controller. It buffers a 512-bit user data stream in a first-word-fall-through FIFO and splits a write job into per-burst write requests. A request for N words is issued only when the FIFO already holds those N words, so the controller never consumes data that has not yet arrived. It sits between the kernel's data generator and the controller's user logic interface.

Parameters:
MAXBURST_LOG, 4, log2 of the maximum burst length in words; must match the controller.
WRITENUM_SIZE, 31, width minus one of the job and request word counts.
DRAM_ADDRSPACE, 32, byte address width.
DRAM_DATAWIDTH, 512, data word width in bits.
FIFO_DEPTH_LOG, 5, log2 of the FIFO depth; must be at least MAXBURST_LOG+1.

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous and active-high
JOB_REQ  in  1  job start; sampled only when JOB_RDY=1
JOB_INITADDR  in  DRAM_ADDRSPACE  job byte start address
JOB_NUM  in  WRITENUM_SIZE+1  job length in words
JOB_RDY  out  1  feeder is idle and can accept a job
JOB_DONE  out  1  one-cycle pulse when the job completes
IN_DATA  in  DRAM_DATAWIDTH  stream data
IN_VALID  in  1  stream data valid
IN_READY  out  1  FIFO can accept a word
WRITE_REQ  out  1  request pulse to the controller
WRITE_INITADDR  out  DRAM_ADDRSPACE  request byte address
WRITE_NUM  out  WRITENUM_SIZE+1  request length (1..2^MAXBURST_LOG)
WRITE_DATA  out  DRAM_DATAWIDTH  FIFO head word
WRITE_DATA_ACCEPTABLE  in  1  controller consumes WRITE_DATA this cycle
WRITE_RDY  in  1  controller is idle
WRITE_REQ_DONE  in  1  controller request completed (writeack seen)
FIFO_COUNT  out  FIFO_DEPTH_LOG+1  current FIFO occupancy
UNDERFLOW_ERR  out  1  sticky: a pop was attempted on an empty FIFO

Behaviour:
- Reset (asynchronous, RST=1). FSM returns to IDLE. FIFO pointers and count clear; FIFO contents are discarded. Output reset values:
  - JOB_RDY=1, IN_READY=1
  - JOB_DONE=0, WRITE_REQ=0, WRITE_INITADDR=0, WRITE_NUM=0, FIFO_COUNT=0, UNDERFLOW_ERR=0
  - WRITE_DATA: don't-care.
- FIFO behaviour:
  - Push when IN_VALID and IN_READY. IN_READY = (FIFO_COUNT < 2^FIFO_DEPTH_LOG); there is no pass-through when full.
  - WRITE_DATA is the head word, available combinationally. Pop when WRITE_DATA_ACCEPTABLE=1.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop while empty: pointers and count are unchanged and UNDERFLOW_ERR is set until reset.
  - A pushed word counts toward FIFO_COUNT on the next cycle.
  - Words beyond the current job stay in the FIFO for the next job.
- Registers: addr, remaining (WRITENUM_SIZE+1 bits), chunk.
  - chunk = min(remaining, 2^MAXBURST_LOG), computed combinationally.
- FSM, IDLE:
  - JOB_RDY=1.
  - JOB_REQ with JOB_NUM=0: JOB_DONE pulses on the next cycle and the FSM stays in IDLE.
  - JOB_REQ with JOB_NUM>0: latch addr=JOB_INITADDR and remaining=JOB_NUM, then go to WAIT_DATA.
- FSM, WAIT_DATA: when FIFO_COUNT >= chunk and WRITE_RDY=1:
  - next cycle WRITE_REQ=1 for exactly one cycle, with WRITE_INITADDR=addr and WRITE_NUM=chunk;
  - latch chunk and go to WAIT_DONE.
- FSM, WAIT_DONE: on WRITE_REQ_DONE:
  - addr += chunk * (DRAM_DATAWIDTH/8), truncated to DRAM_ADDRSPACE bits (address wrap-around allowed);
  - remaining -= chunk;
  - if the new remaining is 0, go to IDLE with JOB_DONE=1 on the next cycle; otherwise go to WAIT_DATA.
- WRITE_REQ_DONE outside WAIT_DONE is ignored.
- WRITE_INITADDR and WRITE_NUM hold their values between requests.
- Only one request is ever outstanding. Every request except the last of a job is a full burst, so the address stride matches the controller's burst stride.
- Cycle counts: the minimum time from the last needed push to WRITE_REQ is 2 cycles. The minimum time from WRITE_REQ_DONE to the next WRITE_REQ is 2 cycles.

Test Plan:
- JOB_NUM=40, JOB_INITADDR=0x1000, continuous stream of words 0..39, controller model attached:
  - requests are (0x1000,16), (0x1400,16), (0x1800,8);
  - WRITE_DATA order is 0..39;
  - JOB_DONE pulses once, 1 cycle after the third WRITE_REQ_DONE;
  - final FIFO_COUNT=0.
- JOB_NUM=0 -> JOB_DONE=1 on the following cycle only, WRITE_REQ never asserted, JOB_RDY stays 1.
- JOB_NUM=16; push 15 words, then stall 20 cycles -> WRITE_REQ stays 0. Push the 16th word -> WRITE_REQ=1 exactly 2 cycles later with WRITE_NUM=16.
- No job, IN_VALID held high for 40 cycles -> FIFO_COUNT=32 and IN_READY=0 from then on; words 32..39 stay held at the input; head word=0.
- Force WRITE_DATA_ACCEPTABLE=1 with an empty FIFO -> UNDERFLOW_ERR=1 and stays 1 through later traffic; FIFO_COUNT stays 0; only RST clears the flag.
- Assert RST in WAIT_DONE with the FIFO holding 10 words -> immediately (no clock edge) WRITE_REQ=0, FIFO_COUNT=0, JOB_RDY=1. After release, a new JOB_NUM=4 job completes normally.
